spi_mem_responder: RTL and testbench

SPI responder (slave) for the system-clocked SPI bus. It owns a 32 x 8 register memory and decodes master frames: single write, single read, and burst read with address auto-increment. MISO is driven low whenever the block is not presenting read data, so several instances can be ORed onto one MISO line. Two instances sit behind the bus master, each selected by its own CS.

---
 rtl/spi_mem_responder.sv | 191 +++++++++++++++++++
 tb/tb_spi_mem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_responder.sv
// SPI responder with a 2**ADDR_W x DATA_W register memory, clocked by the system clock.
// Each frame starts with a header {mode, addr, len}, MSB first. The header is followed by
// one of: a single write, a single read, or a burst read with address auto-increment.
// MISO is held low unless read data is being presented, so instances can be ORed.
//
// Ports:
//   clk        system clock; bus bits are sampled and launched on its rising edge
//   rst        asynchronous active-high reset (also clears the memory)
//   CS         chip select, active low; a frame lasts while CS=0
//   MOSI       serial data from the master, MSB first
//   MISO       serial read data to the master; 0 when idle
//   busy       high while a frame is being decoded
//   wr_strobe  one-cycle pulse when a write commits
//   wr_addr    address of the last committed write
//   wr_data    data of the last committed write
//   frame_err  one-cycle pulse on an aborted or reserved-mode frame
module spi_mem_responder #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 3,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    output logic              busy,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err
);

    localparam int unsigned HDR_W = 2 + ADDR_W + LEN_W;
    localparam int unsigned SH_W  = (HDR_W > DATA_W) ? HDR_W : DATA_W;
    localparam int unsigned CNT_W = $clog2(SH_W);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {StIdle, StHdr, StWrData, StRdData, StDone} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SH_W-2:0]     shift_q, shift_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    left_q, left_d;
    logic                miso_d, wr_strobe_d, frame_err_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [DATA_W-1:0]   wr_data_d;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Shift register including the bit arriving in the current slot.
    logic [SH_W-1:0]     shift_in;
    logic [1:0]          hdr_mode;
    logic [ADDR_W-1:0]   hdr_addr;
    logic [LEN_W-1:0]    hdr_len;
    logic [DATA_W-1:0]   hdr_word;
    logic [ADDR_W-1:0]   next_addr;
    logic [DATA_W-1:0]   next_word;

    assign shift_in  = {shift_q, MOSI};
    assign hdr_mode  = shift_in[HDR_W-1 -: 2];
    assign hdr_addr  = shift_in[LEN_W +: ADDR_W];
    assign hdr_len   = shift_in[LEN_W-1:0];
    assign hdr_word  = mem_q[hdr_addr];
    assign next_addr = addr_q + 1'b1;  // wraps modulo the memory depth
    assign next_word = mem_q[next_addr];
    assign busy      = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        left_d      = left_q;
        miso_d      = 1'b0;
        wr_strobe_d = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr;
        wr_data_d   = wr_data;
        mem_we      = 1'b0;

        if (CS) begin
            // Leaving before the payload completes is an abort.
            if (state_q == StHdr || state_q == StWrData || state_q == StRdData) begin
                frame_err_d = 1'b1;
            end
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    shift_d = shift_in[SH_W-2:0];
                    cnt_d   = CNT_W'(1);
                    state_d = StHdr;
                end
                StHdr: begin
                    shift_d = shift_in[SH_W-2:0];
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(HDR_W - 1)) begin
                        cnt_d  = '0;
                        addr_d = hdr_addr;
                        left_d = (hdr_mode == 2'b10) ? hdr_len : '0;
                        unique case (hdr_mode)
                            2'b00: state_d = StWrData;
                            2'b01, 2'b10: begin
                                // First data bit must be on MISO for the next slot.
                                state_d = StRdData;
                                miso_d  = hdr_word[DATA_W-1];
                                tx_d    = {hdr_word[DATA_W-2:0], 1'b0};
                            end
                            default: begin
                                state_d     = StDone;
                                frame_err_d = 1'b1;
                            end
                        endcase
                    end
                end
                StWrData: begin
                    shift_d = shift_in[SH_W-2:0];
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d       = '0;
                        mem_we      = 1'b1;
                        wr_addr_d   = addr_q;
                        wr_data_d   = shift_in[DATA_W-1:0];
                        wr_strobe_d = 1'b1;
                        state_d     = StDone;
                    end
                end
                StRdData: begin
                    cnt_d  = cnt_q + 1'b1;
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d = '0;
                        if (left_q != '0) begin
                            // Fetch the following word so bursts have no gap.
                            addr_d = next_addr;
                            left_d = left_q - 1'b1;
                            miso_d = next_word[DATA_W-1];
                            tx_d   = {next_word[DATA_W-2:0], 1'b0};
                        end else begin
                            miso_d  = 1'b0;
                            state_d = StDone;
                        end
                    end
                end
                default: ;  // StDone: extra MOSI bits are ignored
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            left_q    <= '0;
            MISO      <= 1'b0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            left_q    <= left_d;
            MISO      <= miso_d;
            wr_strobe <= wr_strobe_d;
            frame_err <= frame_err_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            if (mem_we) begin
                mem_q[addr_q] <= shift_in[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Scoreboard bench for spi_mem_responder: two instances with ORed MISO.
// Stimulus pushes expected writes, errors and read bytes; the monitor pops and compares.
module tb_spi_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cs;
    logic [1:0] mosi;
    logic       miso0, miso1, miso;
    logic       busy0, busy1;
    logic       wr_strobe0, wr_strobe1;
    logic [4:0] wr_addr0, wr_addr1;
    logic [7:0] wr_data0, wr_data1;
    logic       frame_err0, frame_err1;

    assign miso = miso0 | miso1;

    spi_mem_responder u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .CS        (cs[0]),
        .MOSI      (mosi[0]),
        .MISO      (miso0),
        .busy      (busy0),
        .wr_strobe (wr_strobe0),
        .wr_addr   (wr_addr0),
        .wr_data   (wr_data0),
        .frame_err (frame_err0)
    );

    spi_mem_responder u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .CS        (cs[1]),
        .MOSI      (mosi[1]),
        .MISO      (miso1),
        .busy      (busy1),
        .wr_strobe (wr_strobe1),
        .wr_addr   (wr_addr1),
        .wr_data   (wr_data1),
        .frame_err (frame_err1)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [13:0] wr_q [$];  // {inst, addr, data}
    int          err_q [$]; // instance id
    logic [7:0]  rd_q [$];
    logic        rd_window;
    logic        chk_en;
    logic [7:0]  rx;
    int          nb = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [9:0] hdr(input logic [1:0] mode, input logic [4:0] addr,
                                       input logic [2:0] len);
        return {mode, addr, len};
    endfunction

    // Drives one frame, slot i's MOSI bit is bits[n-1-i]. rd_window marks the slots
    // in which read data is expected on the ORed MISO line.
    task automatic xfer(input int inst, input int n, input logic [127:0] bits,
                        input int win_lo, input int win_hi, input bit chk_busy,
                        input int rst_at);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            if (chk_busy && i > 0) chk("busy_in_frame", (inst == 0) ? busy0 : busy1, 1);
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_mid_miso", miso, 0);
                chk("rst_mid_busy", (inst == 0) ? busy0 : busy1, 0);
                cs[inst]   = 1'b1;
                mosi[inst] = 1'b0;
                rd_window  = 1'b0;
                @(posedge clk);
                #2;
                rst = 1'b0;
                return;
            end
            cs[inst]   = 1'b0;
            mosi[inst] = bits[n-1-i];
            if (win_lo >= 0) rd_window = (i >= win_lo && i <= win_hi);
        end
        @(posedge clk);
        #2;
        if (chk_busy) chk("busy_done", (inst == 0) ? busy0 : busy1, 1);
        cs[inst]   = 1'b1;
        mosi[inst] = 1'b0;
        if (win_lo >= 0) rd_window = 1'b0;
        @(posedge clk);
        #2;
        if (chk_busy) chk("busy_after_cs", (inst == 0) ? busy0 : busy1, 0);
    endtask

    // Monitor: samples mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            if (wr_strobe0) begin
                if (wr_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL wr_commit0: unexpected strobe addr %0d data 0x%0h",
                             wr_addr0, wr_data0);
                end else begin
                    chk("wr_commit0", {1'b0, wr_addr0, wr_data0}, wr_q.pop_front());
                end
            end
            if (wr_strobe1) begin
                if (wr_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL wr_commit1: unexpected strobe addr %0d data 0x%0h",
                             wr_addr1, wr_data1);
                end else begin
                    chk("wr_commit1", {1'b1, wr_addr1, wr_data1}, wr_q.pop_front());
                end
            end
            if (frame_err0 || frame_err1) begin
                if (err_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL frame_err: unexpected pulse, got %0b%0b, expected none",
                             frame_err1, frame_err0);
                end else begin
                    chk("frame_err_inst", frame_err1 ? 1 : 0, err_q.pop_front());
                end
            end
            if (rd_window) begin
                rx = {rx[6:0], miso};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (rd_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL rd_byte: got 0x%0h, expected nothing", rx);
                    end else begin
                        chk("rd_byte", rx, rd_q.pop_front());
                    end
                end
            end else begin
                nb = 0;
                chk("idle_miso", miso, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] waddr [4];
        logic [7:0] wdata [4];
        waddr = '{5'd30, 5'd31, 5'd0, 5'd1};
        wdata = '{8'h72, 8'hF3, 8'h11, 8'h22};

        cs = 2'b11; mosi = 2'b00; rst = 1'b1; rd_window = 1'b0; chk_en = 1'b0; rx = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_miso", miso, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_wr_strobe", wr_strobe0, 0);
        chk("rst_wr_addr", wr_addr0, 0);
        chk("rst_wr_data", wr_data0, 0);
        chk("rst_frame_err", frame_err0, 0);
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk_en = 1'b1;

        // 1: read after reset returns the reset value; busy tracks the frame.
        rd_q.push_back(8'h00);
        xfer(0, 18, {hdr(2'b01, 5'd7, 3'd0), 8'h00}, 10, 17, 1, -1);

        // 2: write then read back.
        wr_q.push_back({1'b0, 5'd3, 8'hA5});
        xfer(0, 18, {hdr(2'b00, 5'd3, 3'd0), 8'hA5}, -1, -1, 0, -1);
        rd_q.push_back(8'hA5);
        xfer(0, 18, {hdr(2'b01, 5'd3, 3'd0), 8'h00}, 10, 17, 0, -1);

        // 3: burst of 4 words wrapping 31 -> 0.
        for (int k = 0; k < 4; k++) begin
            wr_q.push_back({1'b0, waddr[k], wdata[k]});
            xfer(0, 18, {hdr(2'b00, waddr[k], 3'd0), wdata[k]}, -1, -1, 0, -1);
        end
        for (int k = 0; k < 4; k++) rd_q.push_back(wdata[k]);
        xfer(0, 42, {hdr(2'b10, 5'd30, 3'd3), 32'h0}, 10, 41, 0, -1);

        // 4: aborted write leaves the old value.
        wr_q.push_back({1'b0, 5'd5, 8'h3C});
        xfer(0, 18, {hdr(2'b00, 5'd5, 3'd0), 8'h3C}, -1, -1, 0, -1);
        err_q.push_back(0);
        xfer(0, 14, {hdr(2'b00, 5'd5, 3'd0), 4'hF}, -1, -1, 0, -1);
        rd_q.push_back(8'h3C);
        xfer(0, 18, {hdr(2'b01, 5'd5, 3'd0), 8'h00}, 10, 17, 0, -1);

        // 5: reserved mode on instance 0 while instance 1 reads on the shared line.
        wr_q.push_back({1'b1, 5'd9, 8'h5A});
        xfer(1, 18, {hdr(2'b00, 5'd9, 3'd0), 8'h5A}, -1, -1, 0, -1);
        err_q.push_back(0);
        rd_q.push_back(8'h5A);
        fork
            xfer(0, 18, {hdr(2'b11, 5'd0, 3'd0), 8'hFF}, -1, -1, 0, -1);
            xfer(1, 18, {hdr(2'b01, 5'd9, 3'd0), 8'h00}, 10, 17, 0, -1);
        join

        // 6: reset during slot 20 of a burst clears everything.
        chk_en = 1'b0;
        xfer(0, 74, {hdr(2'b10, 5'd0, 3'd7), 64'h0}, -1, -1, 0, 20);
        @(posedge clk);
        #2;
        chk("post_rst_wr_addr", wr_addr0, 0);
        chk("post_rst_wr_data", wr_data0, 0);
        chk_en = 1'b1;
        rd_q.push_back(8'h00);
        xfer(0, 18, {hdr(2'b01, 5'd3, 3'd0), 8'h00}, 10, 17, 0, -1);
        rd_q.push_back(8'h00);
        xfer(0, 18, {hdr(2'b01, 5'd30, 3'd0), 8'h00}, 10, 17, 0, -1);
        rd_q.push_back(8'h00);
        xfer(1, 18, {hdr(2'b01, 5'd9, 3'd0), 8'h00}, 10, 17, 0, -1);

        repeat (4) @(posedge clk);
        #2;
        chk("wr_q_drained", wr_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
